// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multi-cycle RV32I control FSM with memory handshake, timeout and sticky halt
module mc_control_fsm #(
  parameter int MEM_HANDSHAKE   = 1,
  parameter int EN_UPPER        = 1,
  parameter int HALT_ON_ILLEGAL = 1,
  parameter int MEM_TIMEOUT     = 255,
  parameter int TO_W            = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       PCUpdate,
  output logic       Branch,
  output logic       AddrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [2:0] ImmSrc,
  output logic       illegal,
  output logic       bus_err,
  output logic       halted,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEMADDR   = 4'd2,
    S_MEMREAD   = 4'd3,
    S_MEMWB     = 4'd4,
    S_MEMWRITE  = 4'd5,
    S_EXEC_R    = 4'd6,
    S_ALUWB     = 4'd7,
    S_EXEC_I    = 4'd8,
    S_JAL       = 4'd9,
    S_BRANCH    = 4'd10,
    S_JALR_ADDR = 4'd11,
    S_LUI       = 4'd12,
    S_AUIPC     = 4'd13,
    S_HALT      = 4'd14
  } state_t;

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_B      = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [TO_W:0] TO_LIMIT = (TO_W + 1)'(MEM_TIMEOUT);

  state_t          state_q, state_d;
  logic [TO_W-1:0] to_q, to_d;
  logic            bus_err_q, bus_err_d;

  logic            rdy;
  logic            mem_state;
  logic [TO_W:0]   to_inc;
  logic            timeout_hit;
  logic            illegal_op;
  logic            mem_req_raw;
  logic            mem_write_raw;
  logic            funct3_unused;

  assign funct3_unused = ^funct3;
  assign rdy           = mem_ready | (MEM_HANDSHAKE == 0);
  assign mem_state     = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
  assign to_inc        = {1'b0, to_q} + (TO_W + 1)'(1);
  assign timeout_hit   = (MEM_TIMEOUT != 0) && (to_inc == TO_LIMIT);

  // Bus strobes are gated by reset so an aborted access is released immediately.
  assign mem_req  = mem_req_raw & ~reset;
  assign MemWrite = mem_write_raw & ~reset;
  assign bus_err  = bus_err_q;
  assign halted   = (state_q == S_HALT);
  assign state_o  = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      to_q      <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      to_q      <= to_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    to_d          = '0;
    bus_err_d     = bus_err_q;
    mem_req_raw   = 1'b0;
    mem_write_raw = 1'b0;
    PCUpdate      = 1'b0;
    Branch        = 1'b0;
    AddrSrc       = 1'b0;
    IRWrite       = 1'b0;
    RegWrite      = 1'b0;
    ResultSrc     = 2'b00;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    ALUOp         = 2'b00;
    illegal       = 1'b0;
    illegal_op    = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req_raw = 1'b1;
        ALUSrcB     = 2'b10;
        ResultSrc   = 2'b10;
        IRWrite     = rdy;
        PCUpdate    = rdy;
        if (rdy) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADDR;
          OP_R:         state_d = S_EXEC_R;
          OP_I:         state_d = S_EXEC_I;
          OP_B:         state_d = S_BRANCH;
          OP_JAL:       state_d = S_JAL;
          OP_JALR:      state_d = S_JALR_ADDR;
          OP_LUI: begin
            if (EN_UPPER != 0) state_d = S_LUI;
            else               illegal_op = 1'b1;
          end
          OP_AUIPC: begin
            if (EN_UPPER != 0) state_d = S_AUIPC;
            else               illegal_op = 1'b1;
          end
          OP_SYSTEM:    state_d = S_HALT;
          default:      illegal_op = 1'b1;
        endcase
        if (illegal_op) begin
          illegal = 1'b1;
          state_d = (HALT_ON_ILLEGAL != 0) ? S_HALT : S_FETCH;
        end
      end
      S_MEMADDR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req_raw = 1'b1;
        AddrSrc     = 1'b1;
        if (rdy) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req_raw   = 1'b1;
        AddrSrc       = 1'b1;
        mem_write_raw = 1'b1;
        if (rdy) state_d = S_FETCH;
      end
      S_EXEC_R: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
        state_d = S_ALUWB;
      end
      S_EXEC_I: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
        state_d = S_ALUWB;
      end
      S_JALR_ADDR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = S_JAL;
      end
      S_JAL: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        PCUpdate = 1'b1;
        state_d  = S_ALUWB;
      end
      S_BRANCH: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        Branch  = 1'b1;
        state_d = S_FETCH;
      end
      S_LUI: begin
        ALUSrcA = 2'b11;
        ALUSrcB = 2'b01;
        state_d = S_ALUWB;
      end
      S_AUIPC: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase

    // A completing access (rdy) always beats the timeout in the same cycle.
    if (mem_state && !rdy) begin
      to_d = to_inc[TO_W-1:0];
      if (timeout_hit) begin
        state_d   = S_HALT;
        bus_err_d = 1'b1;
      end
    end
  end

  always_comb begin
    ImmSrc = 3'b000;
    case (op)
      OP_SW:           ImmSrc = 3'b001;
      OP_B:            ImmSrc = 3'b010;
      OP_JAL:          ImmSrc = 3'b011;
      OP_LUI, OP_AUIPC: ImmSrc = 3'b100;
      default:         ImmSrc = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - table-driven and sequence checks for mc_control_fsm
module tb_mc_control_fsm;

  typedef struct {
    logic [6:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [14:0] ctl;
    logic [2:0]  imm;
    logic [2:0]  fl;
  } vec_t;

  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LW = 7'b0000011, SW = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011, JL = 7'b1101111, JR = 7'b1100111;
  localparam logic [6:0] LU = 7'b0110111, AU = 7'b0010111, SY = 7'b1110011;

  // {mem_req,PCUpdate,Branch,AddrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp}
  localparam logic [14:0] C_F   = 15'b1100010_10_00_10_00;
  localparam logic [14:0] C_FW  = 15'b1000000_10_00_10_00;
  localparam logic [14:0] C_D   = 15'b0000000_00_01_01_00;
  localparam logic [14:0] C_MA  = 15'b0000000_00_10_01_00;
  localparam logic [14:0] C_MR  = 15'b1001000_00_00_00_00;
  localparam logic [14:0] C_MWB = 15'b0000001_01_00_00_00;
  localparam logic [14:0] C_MW  = 15'b1001100_00_00_00_00;
  localparam logic [14:0] C_XR  = 15'b0000000_00_10_00_10;
  localparam logic [14:0] C_XI  = 15'b0000000_00_10_01_10;
  localparam logic [14:0] C_J   = 15'b0100000_00_01_10_00;
  localparam logic [14:0] C_B   = 15'b0010000_00_10_00_01;
  localparam logic [14:0] C_JA  = 15'b0000000_00_10_01_00;
  localparam logic [14:0] C_LU  = 15'b0000000_00_11_01_00;
  localparam logic [14:0] C_AU  = 15'b0000000_00_01_01_00;
  localparam logic [14:0] C_WB  = 15'b0000001_00_00_00_00;
  localparam logic [14:0] C_H   = 15'b0000000_00_00_00_00;

  logic clk = 1'b0;
  logic reset;
  logic [6:0] op;
  logic [2:0] funct3 = 3'b000;
  logic mem_ready;

  logic mem_req, PCUpdate, Branch, AddrSrc, MemWrite, IRWrite, RegWrite, illegal, bus_err, halted;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [2:0] ImmSrc;
  logic [3:0] state_o;

  logic b_mem_req, b_PCUpdate, b_Branch, b_AddrSrc, b_MemWrite, b_IRWrite, b_RegWrite, b_illegal, b_bus_err, b_halted;
  logic [1:0] b_ResultSrc, b_ALUSrcA, b_ALUSrcB, b_ALUOp;
  logic [2:0] b_ImmSrc;
  logic [3:0] b_state_o;

  logic [14:0] act_ctl;
  assign act_ctl = {mem_req, PCUpdate, Branch, AddrSrc, MemWrite, IRWrite, RegWrite,
                    ResultSrc, ALUSrcA, ALUSrcB, ALUOp};

  always #5 clk = ~clk;

  mc_control_fsm #(.MEM_HANDSHAKE(1), .EN_UPPER(1), .HALT_ON_ILLEGAL(1), .MEM_TIMEOUT(4), .TO_W(8)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .mem_ready(mem_ready),
    .mem_req(mem_req), .PCUpdate(PCUpdate), .Branch(Branch), .AddrSrc(AddrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .ImmSrc(ImmSrc), .illegal(illegal), .bus_err(bus_err), .halted(halted), .state_o(state_o)
  );

  mc_control_fsm #(.MEM_HANDSHAKE(1), .EN_UPPER(0), .HALT_ON_ILLEGAL(0), .MEM_TIMEOUT(4), .TO_W(8)) dut2 (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .mem_ready(mem_ready),
    .mem_req(b_mem_req), .PCUpdate(b_PCUpdate), .Branch(b_Branch), .AddrSrc(b_AddrSrc), .MemWrite(b_MemWrite),
    .IRWrite(b_IRWrite), .RegWrite(b_RegWrite), .ResultSrc(b_ResultSrc), .ALUSrcA(b_ALUSrcA), .ALUSrcB(b_ALUSrcB),
    .ALUOp(b_ALUOp), .ImmSrc(b_ImmSrc), .illegal(b_illegal), .bus_err(b_bus_err), .halted(b_halted), .state_o(b_state_o)
  );

  int   n_checks = 0;
  int   n_err    = 0;
  vec_t tbl[$];
  vec_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [6:0] o, input logic r, input logic [3:0] s,
                     input logic [14:0] c, input logic [2:0] im, input logic [2:0] fl);
    vec_t v;
    v.op = o; v.rdy = r; v.st = s; v.ctl = c; v.imm = im; v.fl = fl;
    tbl.push_back(v);
  endtask

  task automatic fd(input logic [6:0] o, input logic [2:0] im);
    add(o, 1'b1, 4'd0, C_F, im, 3'b000);
    add(o, 1'b1, 4'd1, C_D, im, 3'b000);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst state", 32'(state_o), 32'd0);
    chk("rst bus_err", 32'(bus_err), 32'd0);
    chk("rst halted", 32'(halted), 32'd0);
    chk("rst mem_req", 32'(mem_req), 32'd0);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; op = R; mem_ready = 1'b0;

    fd(R, 3'b000);  add(R, 1, 4'd6, C_XR, 3'b000, 0);  add(R, 1, 4'd7, C_WB, 3'b000, 0);
    fd(I, 3'b000);  add(I, 1, 4'd8, C_XI, 3'b000, 0);  add(I, 1, 4'd7, C_WB, 3'b000, 0);
    fd(LW, 3'b000); add(LW, 1, 4'd2, C_MA, 3'b000, 0);
    for (int k = 0; k < 3; k++) add(LW, 0, 4'd3, C_MR, 3'b000, 0);
    add(LW, 1, 4'd3, C_MR, 3'b000, 0); add(LW, 1, 4'd4, C_MWB, 3'b000, 0);
    fd(SW, 3'b001); add(SW, 1, 4'd2, C_MA, 3'b001, 0);
    for (int k = 0; k < 2; k++) add(SW, 0, 4'd5, C_MW, 3'b001, 0);
    add(SW, 1, 4'd5, C_MW, 3'b001, 0);
    for (int k = 0; k < 3; k++) add(R, 0, 4'd0, C_FW, 3'b000, 0);
    add(R, 1, 4'd0, C_F, 3'b000, 0); add(R, 1, 4'd1, C_D, 3'b000, 0);
    add(R, 1, 4'd6, C_XR, 3'b000, 0); add(R, 1, 4'd7, C_WB, 3'b000, 0);
    fd(BR, 3'b010); add(BR, 1, 4'd10, C_B, 3'b010, 0);
    fd(JL, 3'b011); add(JL, 1, 4'd9, C_J, 3'b011, 0);  add(JL, 1, 4'd7, C_WB, 3'b011, 0);
    fd(JR, 3'b000); add(JR, 1, 4'd11, C_JA, 3'b000, 0); add(JR, 1, 4'd9, C_J, 3'b000, 0);
    add(JR, 1, 4'd7, C_WB, 3'b000, 0);
    fd(LU, 3'b100); add(LU, 1, 4'd12, C_LU, 3'b100, 0); add(LU, 1, 4'd7, C_WB, 3'b100, 0);
    fd(AU, 3'b100); add(AU, 1, 4'd13, C_AU, 3'b100, 0); add(AU, 1, 4'd7, C_WB, 3'b100, 0);
    fd(SY, 3'b000); add(SY, 1, 4'd14, C_H, 3'b000, 3'b001); add(SY, 1, 4'd14, C_H, 3'b000, 3'b001);

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      vec_t e;
      op = tbl[i].op;
      mem_ready = tbl[i].rdy;
      exp_q.push_back(tbl[i]);
      #1;
      e = exp_q.pop_front();
      chk($sformatf("row%0d state", i), 32'(state_o), 32'(e.st));
      chk($sformatf("row%0d ctl", i), 32'(act_ctl), 32'(e.ctl));
      chk($sformatf("row%0d imm", i), 32'(ImmSrc), 32'(e.imm));
      chk($sformatf("row%0d flags", i), 32'({illegal, bus_err, halted}), 32'(e.fl));
      @(negedge clk);
    end

    // Timeout: four waiting FETCH cycles, then HALT with a sticky bus error.
    do_reset();
    op = R; mem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("to wait%0d state", k), 32'(state_o), 32'd0);
      chk($sformatf("to wait%0d bus_err", k), 32'(bus_err), 32'd0);
      @(negedge clk);
    end
    chk("to halt state", 32'(state_o), 32'd14);
    chk("to bus_err", 32'(bus_err), 32'd1);
    chk("to halted", 32'(halted), 32'd1);
    chk("to mem_req", 32'(mem_req), 32'd0);
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("to sticky state", 32'(state_o), 32'd14);
    chk("to sticky bus_err", 32'(bus_err), 32'd1);
    do_reset();

    // Illegal opcode: halts on dut, returns to FETCH on dut2.
    op = 7'b0000000; mem_ready = 1'b1;
    @(negedge clk);
    chk("ill dec state", 32'(state_o), 32'd1);
    chk("ill pulse", 32'(illegal), 32'd1);
    chk("ill pulse b", 32'(b_illegal), 32'd1);
    @(negedge clk);
    chk("ill halt state", 32'(state_o), 32'd14);
    chk("ill halted", 32'(halted), 32'd1);
    chk("ill pulse end", 32'(illegal), 32'd0);
    chk("ill b state", 32'(b_state_o), 32'd0);
    chk("ill b pulse end", 32'(b_illegal), 32'd0);
    do_reset();

    // LUI with upper ops disabled is illegal on dut2 only.
    op = LU; mem_ready = 1'b1;
    @(negedge clk);
    chk("lui ill b", 32'(b_illegal), 32'd1);
    chk("lui ill a", 32'(illegal), 32'd0);
    @(negedge clk);
    chk("lui a state", 32'(state_o), 32'd12);
    chk("lui b state", 32'(b_state_o), 32'd0);
    do_reset();

    // Asynchronous reset in the middle of a stalled store.
    op = SW; mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    mem_ready = 1'b0;
    #1;
    chk("ar memwrite state", 32'(state_o), 32'd5);
    chk("ar MemWrite pre", 32'(MemWrite), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("ar mem_req", 32'(mem_req), 32'd0);
    chk("ar MemWrite", 32'(MemWrite), 32'd0);
    chk("ar state", 32'(state_o), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
